// File: rtl/encoder_pipe_n.sv
// Registered N-to-log2(N) encoder: strict one-hot, fixed-priority or round-robin selection,
// with a single output register stage and valid/ready handshakes on both sides.
module encoder_pipe_n #(
  parameter int unsigned N    = 32,
  parameter int unsigned W    = $clog2(N),
  parameter int unsigned MODE = 0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] enc_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] enc_out,
  output logic         out_none,
  output logic         out_err,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0]           r_enc;
  logic                   r_none;
  logic                   r_err;
  logic                   r_valid;
  logic [W-1:0]           r_ptr;

  logic [W-1:0]           w_idx;
  logic [W-1:0]           w_ptr_nxt;
  logic                   w_none;
  logic                   w_err;
  logic                   w_accept;
  logic                   w_hit;
  logic [W:0]             w_pos;
  logic [$clog2(N+1)-1:0] w_cnt;

  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_ptr_nxt = (32'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;

  always_comb begin
    w_idx  = '1;
    w_none = 1'b1;
    w_err  = 1'b0;
    w_hit  = 1'b0;
    w_pos  = '0;
    w_cnt  = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (enc_in[i]) begin
          w_cnt = w_cnt + 1'b1;
          w_idx = i[W-1:0];
        end
      end
      if (w_cnt == 1) begin
        w_none = 1'b0;
      end else begin
        w_idx = '1;
        w_err = 1'b1;
      end
    end else if (MODE == 1) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (enc_in[i]) begin
          w_idx  = i[W-1:0];
          w_none = 1'b0;
        end
      end
    end else begin
      // Rotating scan starting at r_ptr; the first set bit found wins.
      for (int j = 0; j < N; j++) begin
        w_pos = {1'b0, r_ptr} + j[W:0];
        if (w_pos >= (W+1)'(N)) begin
          w_pos = w_pos - (W+1)'(N);
        end
        if (!w_hit && enc_in[w_pos]) begin
          w_hit  = 1'b1;
          w_idx  = w_pos[W-1:0];
          w_none = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_valid <= 1'b0;
      r_enc   <= '1;
      r_none  <= 1'b1;
      r_err   <= 1'b0;
      r_ptr   <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_enc   <= w_idx;
      r_none  <= w_none;
      r_err   <= w_err;
      if (MODE == 2 && !w_none) begin
        r_ptr <= w_ptr_nxt;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign enc_out   = r_enc;
  assign out_none  = r_none;
  assign out_err   = r_err;
  assign out_valid = r_valid;

endmodule
